// File: rtl/msg_pkg.sv
// Shared types for the message output path: queued message bundle and
// the saturating statistic increment.
package msg_pkg;

   localparam int MAX_MSG_BYTES_DEF = 32;
   localparam int MSG_DATA_W        = 8 * MAX_MSG_BYTES_DEF;

   typedef struct packed {
      logic [15:0]           length;
      logic [MSG_DATA_W-1:0] data;
      logic                  error;
   } msg_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/msg_fifo.sv
// First-word-fall-through FIFO of msg_t entries; full/empty come from
// the occupancy count so the pointers can simply wrap.
module msg_fifo
   import msg_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  msg_t          i_data,
   input  logic          i_pop,
   output msg_t          o_data,
   output logic          o_valid,
   output logic          o_full,
   output logic [LW-1:0] o_level
);

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   msg_t          r_mem [DEPTH];

   logic w_pop;
   logic w_push;

   assign o_valid = (r_level != '0);
   assign o_full  = (r_level == LW'(DEPTH));
   assign o_level = r_level;
   assign o_data  = r_mem[r_rd_ptr];

   // A push into a full FIFO is only legal when the head leaves this cycle.
   assign w_pop  = i_pop & o_valid;
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/msg_out_queue.sv
// Buffers parser message strobes, masks unused payload bytes and keeps
// saturating drop/error statistics; re-presents messages as valid/ready.
module msg_out_queue
   import msg_pkg::*;
#(
   parameter int MAX_MSG_BYTES = MAX_MSG_BYTES_DEF,
   parameter int DEPTH         = 4,
   parameter bit DROP_ERRORED  = 1'b1,
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_msg_valid,
   input  logic [15:0]                in_msg_length,
   input  logic [8*MAX_MSG_BYTES-1:0] in_msg_data,
   input  logic                       in_msg_error,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [15:0]                out_length,
   output logic [8*MAX_MSG_BYTES-1:0] out_data,
   output logic                       out_error,
   output logic [LW-1:0]              level,
   output logic [15:0]                overflow_cnt,
   output logic [15:0]                error_cnt,
   output logic                       overflow_flag
);

   logic                       w_len_over;
   logic                       w_err_q;
   logic                       w_push_req;
   logic                       w_push;
   logic                       w_pop;
   logic                       w_drop;
   logic                       w_fifo_valid;
   logic                       w_fifo_full;
   logic [LW-1:0]              w_level;
   logic [8*MAX_MSG_BYTES-1:0] w_masked;
   msg_t                       w_wr_msg;
   msg_t                       w_head;

   logic [15:0] r_ovf_cnt;
   logic [15:0] r_err_cnt;
   logic        r_ovf_flag;

   assign w_len_over = (in_msg_length > 16'(MAX_MSG_BYTES));
   assign w_err_q    = in_msg_error | (in_msg_length == 16'd0) | w_len_over;
   assign w_push_req = in_msg_valid & ~(w_err_q & DROP_ERRORED);

   assign w_pop  = w_fifo_valid & out_ready;
   assign w_push = w_push_req & (~w_fifo_full | w_pop);
   assign w_drop = w_push_req & ~w_push;

   // Oversized lengths only reach storage as errored entries; keep them raw.
   always_comb begin
      w_masked = in_msg_data;
      for (int i = 0; i < MAX_MSG_BYTES; i++) begin
         if (!w_len_over && (16'(i) >= in_msg_length))
            w_masked[8*i +: 8] = 8'h00;
      end
   end

   assign w_wr_msg = '{length: in_msg_length, data: w_masked, error: w_err_q};

   msg_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_wr_msg),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_valid (w_fifo_valid),
      .o_full  (w_fifo_full),
      .o_level (w_level)
   );

   assign out_valid  = w_fifo_valid;
   assign out_length = w_fifo_valid ? w_head.length : '0;
   assign out_data   = w_fifo_valid ? w_head.data : '0;
   assign out_error  = w_fifo_valid & w_head.error;
   assign level      = w_level;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf_cnt  <= '0;
         r_err_cnt  <= '0;
         r_ovf_flag <= 1'b0;
      end else begin
         if (in_msg_valid && w_err_q) r_err_cnt <= sat_inc16(r_err_cnt);
         if (w_drop) begin
            r_ovf_cnt  <= sat_inc16(r_ovf_cnt);
            r_ovf_flag <= 1'b1;
         end
      end
   end

   assign overflow_cnt  = r_ovf_cnt;
   assign error_cnt     = r_err_cnt;
   assign overflow_flag = r_ovf_flag;

endmodule

// File: tb/tb_msg_out_queue.sv
// Randomised and directed bench for msg_out_queue with both error policies,
// checked every cycle against a queue-based model.
module tb_msg_out_queue;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_msg_valid = 1'b0;
   logic [15:0]  in_msg_length = '0;
   logic [255:0] in_msg_data = '0;
   logic         in_msg_error = 1'b0;
   logic         out_ready = 1'b0;

   logic         a_valid, b_valid;
   logic [15:0]  a_len, b_len;
   logic [255:0] a_data, b_data;
   logic         a_err, b_err;
   logic [2:0]   a_lvl, b_lvl;
   logic [15:0]  a_oc, b_oc, a_ec, b_ec;
   logic         a_fl, b_fl;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   msg_out_queue #(.MAX_MSG_BYTES(32), .DEPTH(4), .DROP_ERRORED(1'b1)) dut_a (
      .clk(clk), .rst(rst),
      .in_msg_valid(in_msg_valid), .in_msg_length(in_msg_length),
      .in_msg_data(in_msg_data), .in_msg_error(in_msg_error),
      .out_valid(a_valid), .out_ready(out_ready),
      .out_length(a_len), .out_data(a_data), .out_error(a_err),
      .level(a_lvl), .overflow_cnt(a_oc), .error_cnt(a_ec),
      .overflow_flag(a_fl)
   );

   msg_out_queue #(.MAX_MSG_BYTES(32), .DEPTH(4), .DROP_ERRORED(1'b0)) dut_b (
      .clk(clk), .rst(rst),
      .in_msg_valid(in_msg_valid), .in_msg_length(in_msg_length),
      .in_msg_data(in_msg_data), .in_msg_error(in_msg_error),
      .out_valid(b_valid), .out_ready(out_ready),
      .out_length(b_len), .out_data(b_data), .out_error(b_err),
      .level(b_lvl), .overflow_cnt(b_oc), .error_cnt(b_ec),
      .overflow_flag(b_fl)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [15:0]  len;
      logic [255:0] data;
      logic         err;
   } ent_t;

   ent_t        mq [2][$];
   logic [15:0] m_oc [2];
   logic [15:0] m_ec [2];
   logic        m_fl [2];

   function automatic logic [15:0] sat(input logic [15:0] v);
      int n;
      n = int'(v) + 1;
      return (n > 65535) ? 16'hFFFF : 16'(n);
   endfunction

   function automatic logic [255:0] mask(input logic [15:0] len,
                                         input logic [255:0] d);
      logic [255:0] r;
      r = d;
      if (len <= 16'd32)
         for (int i = 0; i < 32; i++)
            if (i >= int'(len)) r[8*i +: 8] = 8'h00;
      return r;
   endfunction

   task automatic model_step(input int d, input logic drop);
      logic errq, pop, full, preq;
      ent_t e;
      errq = in_msg_error || in_msg_length == 0 || in_msg_length > 32;
      if (in_msg_valid && errq) m_ec[d] = sat(m_ec[d]);
      pop  = (mq[d].size() > 0) && out_ready;
      full = (mq[d].size() >= 4);
      preq = in_msg_valid && !(errq && drop);
      if (pop) void'(mq[d].pop_front());
      if (preq) begin
         if (!full || pop) begin
            e.len  = in_msg_length;
            e.data = mask(in_msg_length, in_msg_data);
            e.err  = errq;
            mq[d].push_back(e);
         end else begin
            m_oc[d] = sat(m_oc[d]);
            m_fl[d] = 1'b1;
         end
      end
   endtask

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         mq[d].delete();
         m_oc[d] = '0;
         m_ec[d] = '0;
         m_fl[d] = 1'b0;
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [255:0] act,
                      input logic [255:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cmp_dut(input int d, input string t, input logic v,
                          input logic [15:0] len, input logic [255:0] dat,
                          input logic err, input logic [2:0] lvl,
                          input logic [15:0] oc, input logic [15:0] ec,
                          input logic fl);
      chk({t, " valid"}, 256'(v), 256'(mq[d].size() > 0));
      chk({t, " level"}, 256'(lvl), 256'(mq[d].size()));
      chk({t, " ovf_cnt"}, 256'(oc), 256'(m_oc[d]));
      chk({t, " err_cnt"}, 256'(ec), 256'(m_ec[d]));
      chk({t, " ovf_flag"}, 256'(fl), 256'(m_fl[d]));
      if (mq[d].size() > 0) begin
         chk({t, " length"}, 256'(len), 256'(mq[d][0].len));
         chk({t, " data"}, dat, mq[d][0].data);
         chk({t, " error"}, 256'(err), 256'(mq[d][0].err));
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         cmp_dut(0, "A", a_valid, a_len, a_data, a_err, a_lvl, a_oc, a_ec, a_fl);
         cmp_dut(1, "B", b_valid, b_len, b_data, b_err, b_lvl, b_oc, b_ec, b_fl);
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   task automatic step(input logic v, input logic [15:0] len,
                       input logic [255:0] dat, input logic err,
                       input logic rdy);
      in_msg_valid  = v;
      in_msg_length = len;
      in_msg_data   = dat;
      in_msg_error  = err;
      out_ready     = rdy;
      @(posedge clk);
      model_step(0, 1'b1);
      model_step(1, 1'b0);
      #1;
      in_msg_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_msg_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst A valid", 256'(a_valid), 256'd0);
      chk("rst A level", 256'(a_lvl), 256'd0);
      chk("rst B valid", 256'(b_valid), 256'd0);
      chk("rst B level", 256'(b_lvl), 256'd0);
      chk("rst A length", 256'(a_len), 256'd0);
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic fill4();
      for (int k = 0; k < 4; k++) step(1'b1, 16'(k + 1), rnd256(), 1'b0, 1'b0);
   endtask

   initial begin
      logic [255:0] d1;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      chk("init ovf_cnt", 256'(a_oc), 256'd0);
      chk("init flag", 256'(a_fl), 256'd0);

      // single short message, garbage above the length
      d1 = {{27{8'h55}}, 40'hAABBCCDDEE};
      step(1'b1, 16'd5, d1, 1'b0, 1'b1);
      chk("t1 valid", 256'(a_valid), 256'd1);
      chk("t1 length", 256'(a_len), 256'd5);
      chk("t1 data", a_data, 256'hAABBCCDDEE);
      step(1'b0, 16'd0, '0, 1'b0, 1'b1);
      chk("t1 level", 256'(a_lvl), 256'd0);

      // overflow then ordered drain
      do_reset();
      for (int k = 0; k < 6; k++) step(1'b1, 16'(k + 1), rnd256(), 1'b0, 1'b0);
      chk("t2 level", 256'(a_lvl), 256'd4);
      chk("t2 ovf_cnt", 256'(a_oc), 256'd2);
      chk("t2 flag", 256'(a_fl), 256'd1);
      for (int k = 0; k < 4; k++) begin
         chk("t2 order", 256'(a_len), 256'(k + 1));
         step(1'b0, 16'd0, '0, 1'b0, 1'b1);
      end
      chk("t2 drained", 256'(a_lvl), 256'd0);

      // push into full FIFO while popping
      do_reset();
      fill4();
      step(1'b1, 16'd9, rnd256(), 1'b0, 1'b1);
      chk("t3 level", 256'(a_lvl), 256'd4);
      chk("t3 ovf_cnt", 256'(a_oc), 256'd0);
      chk("t3 head", 256'(a_len), 256'd2);

      // error qualification under both policies
      do_reset();
      step(1'b1, 16'd4, rnd256(), 1'b1, 1'b0);
      step(1'b1, 16'd0, rnd256(), 1'b0, 1'b0);
      step(1'b1, 16'd40, rnd256(), 1'b0, 1'b0);
      chk("t4 A err_cnt", 256'(a_ec), 256'd3);
      chk("t4 A level", 256'(a_lvl), 256'd0);
      chk("t4 B err_cnt", 256'(b_ec), 256'd3);
      chk("t4 B level", 256'(b_lvl), 256'd3);
      for (int k = 0; k < 3; k++) begin
         chk("t4 B out_error", 256'(b_err), 256'd1);
         step(1'b0, 16'd0, '0, 1'b0, 1'b1);
      end

      // overflow counter saturation
      do_reset();
      fill4();
      for (int k = 0; k < 65540; k++) step(1'b1, 16'd8, d1, 1'b0, 1'b0);
      chk("t5 A ovf sat", 256'(a_oc), 256'hFFFF);
      chk("t5 B ovf sat", 256'(b_oc), 256'hFFFF);

      // reset mid-drain, then a fresh message
      do_reset();
      fill4();
      step(1'b0, 16'd0, '0, 1'b0, 1'b1);
      chk("t6 level pre", 256'(a_lvl), 256'd3);
      do_reset();
      step(1'b1, 16'd3, d1, 1'b0, 1'b0);
      chk("t6 length", 256'(a_len), 256'd3);
      chk("t6 data", a_data, 256'hCCDDEE);

      // random traffic with one mid-run reset
      for (int n = 0; n < 3000; n++) begin
         logic [15:0] len;
         int sel;
         sel = $urandom_range(0, 9);
         if (sel == 0) len = 16'd0;
         else if (sel == 1) len = 16'($urandom_range(33, 40));
         else len = 16'($urandom_range(1, 32));
         if (n == 1500) do_reset();
         step(($urandom_range(0, 3) != 0), len, rnd256(),
              ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1);
      end

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
